// File: rtl/escape_iterator.sv
// Mandelbrot escape-time engine: maps a raster pixel to c, iterates z <- z^2 + c in Q4.12.
// Latency: n+2 cycles from acceptance to out_valid (n = final count, minimum 1 so minimum 3).
// Backpressure: one pixel in flight; in_ready low until the result is taken, DONE holds indefinitely.
module escape_iterator #(
  parameter int unsigned        MAX_ITER = 255,
  parameter logic signed [15:0] X_MIN    = 16'shE000,
  parameter logic signed [15:0] Y_MIN    = 16'shEE00,
  parameter logic        [15:0] STEP     = 16'd12
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] out_x,
  output logic [9:0] out_y,
  output logic [7:0] out_iter,
  output logic       out_sof,
  output logic       out_eol
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic signed [15:0] r_cr, r_ci, r_zr, r_zi;
  logic        [7:0]  r_n;
  logic        [9:0]  r_x, r_y;
  logic        [7:0]  r_iter;
  logic               r_sof, r_eol;

  logic               w_accept, w_exit;
  logic        [15:0] w_cr_init, w_ci_init;
  logic signed [31:0] w_zr2, w_zi2, w_zrzi, w_diff;
  logic        [32:0] w_mag;
  logic               w_escape;
  logic signed [15:0] w_zr_nxt, w_zi_nxt;

  // c for the incoming pixel; 16-bit arithmetic gives the required truncation for free
  assign w_cr_init = X_MIN + 16'({6'd0, x}) * STEP;
  assign w_ci_init = Y_MIN + 16'({6'd0, y}) * STEP;

  // Q8.24 products of the current z
  assign w_zr2    = r_zr * r_zr;
  assign w_zi2    = r_zi * r_zi;
  assign w_zrzi   = r_zr * r_zi;
  assign w_diff   = w_zr2 - w_zi2;
  // Both squares are non-negative, so zero-extension yields the exact magnitude
  assign w_mag    = {1'b0, w_zr2} + {1'b0, w_zi2};
  assign w_escape = (w_mag > 33'h0400_0000);

  // (2*p) >>> 12 equals p >>> 11 exactly, so the doubling folds into the shift
  assign w_zr_nxt = 16'(w_diff >>> 12) + r_cr;
  assign w_zi_nxt = 16'(w_zrzi >>> 11) + r_ci;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_x     = r_x;
  assign out_y     = r_y;
  assign out_iter  = r_iter;
  assign out_sof   = r_sof;
  assign out_eol   = r_eol;

  // Next-state: accept in IDLE, iterate until escape/cap, hold result until taken
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = in_valid;
        if (in_valid) w_state_nxt = ITER;
      end
      ITER: begin
        w_exit = w_escape || (r_n == 8'(MAX_ITER));
        if (w_exit) w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Datapath: load pixel on accept, one z update per ITER cycle, latch count on exit
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cr   <= '0;
      r_ci   <= '0;
      r_zr   <= '0;
      r_zi   <= '0;
      r_n    <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_iter <= '0;
      r_sof  <= 1'b0;
      r_eol  <= 1'b0;
    end else if (w_accept) begin
      r_cr  <= w_cr_init;
      r_ci  <= w_ci_init;
      r_zr  <= '0;
      r_zi  <= '0;
      r_n   <= '0;
      r_x   <= x;
      r_y   <= y;
      r_sof <= (x == 10'd0) && (y == 10'd0);
      r_eol <= (x == 10'd1023);
    end else if (r_state == ITER) begin
      if (w_exit) begin
        r_iter <= r_n;
      end else begin
        r_zr <= w_zr_nxt;
        r_zi <= w_zi_nxt;
        r_n  <= r_n + 8'd1;
      end
    end
  end

endmodule

// File: doc/escape_iterator.md
# escape_iterator

Per-pixel Mandelbrot escape-time engine for the accelerator datapath. It consumes raster coordinates (X 0..1023, Y 0..767) from the raster counter and maps each pixel to a point c in the complex plane. It iterates z ← z² + c in Q4.12 fixed point until the point escapes or MAX_ITER is reached, then presents the iteration count to the downstream colour/stream stage with a valid/ready handshake. Its `in_ready` output drives the raster counter's `en`, so the counter advances exactly one pixel per accepted coordinate.

## Interface
Parameters:
- `MAX_ITER`, default 255: iteration cap, range 1..255.
- `X_MIN`, default 16'shE000 (−2.0): real part of c at X=0, signed Q4.12.
- `Y_MIN`, default 16'shEE00 (−1.125): imaginary part of c at Y=0, signed Q4.12.
- `STEP`, default 16'd12: per-pixel increment of c in Q4.12 LSBs. This spans 3.0 across X and 2.25 across Y.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset. One clock; reset is asynchronous and active-low.
- `in_valid` in 1: coordinate valid.
- `in_ready` out 1: engine idle and able to accept; wired to the raster counter `en`.
- `x` in 10: pixel column.
- `y` in 10: pixel row.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_x` out 10: column of the result.
- `out_y` out 10: row of the result.
- `out_iter` out 8: escape iteration count.
- `out_sof` out 1: start of frame, high when out_x==0 and out_y==0.
- `out_eol` out 1: end of line, high when out_x==1023.

## Operation
- FSM states: IDLE, ITER, DONE.
- IDLE
  - `in_ready`=1.
  - When `in_valid`=1, the engine captures x and y and computes cr = X_MIN + x·STEP and ci = Y_MIN + y·STEP, each truncated to 16 bits.
  - It sets zr=zi=0 and n=0, then goes to ITER.
- ITER: one iteration per cycle.
  - Squares zr², zi² and product zr·zi are full 32-bit signed products (Q8.24).
  - mag = zr² + zi², 33-bit unsigned. Escape when mag > 0x400_0000 (4.0 in Q8.24); strictly greater-than.
  - If escape or n==MAX_ITER: latch out_iter=n and go to DONE. z is not updated.
  - Otherwise:
    - zr ← ((zr² − zi²) >>> 12) + cr.
    - zi ← ((2·zr·zi) >>> 12) + ci.
    - n ← n+1.
    - Arithmetic shift, result truncated to 16 bits. No overflow is possible, because |zr|,|zi| ≤ 2 whenever no escape occurs, so results stay within ±6.
- DONE
  - `out_valid`=1; `out_x`/`out_y`/`out_iter`/`out_sof`/`out_eol` are held stable.
  - On `out_valid && out_ready`, go to IDLE.
- `in_ready` is high only in IDLE, so there is never more than one pixel in flight.
- An input handshake and an output handshake never occur in the same cycle.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_x`=0, `out_y`=0, `out_iter`=0, `out_sof`=0, `out_eol`=0, internal z/c/n=0.
- Accept in cycle T.
  - ITER occupies cycles T+1 .. T+n+1, where n is the final count.
  - `out_valid` rises at T+n+2.
  - Minimum latency is 2 cycles (n=0 is impossible with z=0, so the minimum actual latency is 3).
- `in_ready` falls the cycle after acceptance and rises the cycle after the output handshake.
- Back-to-back pixel throughput = n+3 cycles per pixel with `out_ready` tied high.
- `out_ready` low in DONE: the engine stalls indefinitely with all outputs held and `in_ready`=0.
- `aresetn` asserted in any state: the engine returns to IDLE immediately (asynchronous). The in-flight pixel is discarded and no `out_valid` is produced for it.
- `in_valid` is ignored outside IDLE. No input state is sampled while `in_ready`=0.

## Test plan
- Reset: assert `aresetn`=0 mid-run → all outputs at reset values asynchronously (before the next edge). Release → `in_ready`=1, `out_valid`=0.
- Pixel (0,0), defaults: c=(−2.0, −1.125) → `out_iter`=1, `out_sof`=1, `out_eol`=0, `out_valid` exactly 3 cycles after acceptance.
- Pixel (683,384): c=(4/4096, 0), inside the set → `out_iter`=255, `out_valid` 257 cycles after acceptance.
- Pixel (1023,767) → `out_eol`=1, `out_sof`=0, `out_x`=1023, `out_y`=767.
- Backpressure: `out_ready`=0 for 20 cycles in DONE → outputs stable and `in_ready`=0 throughout. Raise `out_ready` → one handshake, then `in_ready`=1 next cycle.
- Reset during ITER for pixel (683,384) at cycle 50 → no `out_valid`. The next pixel, (0,0), completes with `out_iter`=1.
